// File: rtl/muldiv_unit_if.sv
// Issue/result bundle between the execute stage, the mul/div unit and the HI/LO register.
interface muldiv_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             cancel;
  logic             busy;
  logic             write_hi;
  logic             write_lo;
  logic [WIDTH-1:0] out_hi;
  logic [WIDTH-1:0] out_lo;

  modport master (
    output start, op, rs_data, rt_data, cancel,
    input  busy, write_hi, write_lo, out_hi, out_lo
  );

  modport slave (
    input  start, op, rs_data, rt_data, cancel,
    output busy, write_hi, write_lo, out_hi, out_lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one shift-add or restoring-divide step per cycle on
// operand magnitudes, sign fix-up in a final cycle, then a one-cycle HI/LO write pulse.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic               r_is_div;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [CW-1:0]      r_count;
  logic [WIDTH-1:0]   r_out_hi;
  logic [WIDTH-1:0]   r_out_lo;
  logic               r_write;

  logic               w_accept;
  logic               w_last;
  logic               w_signed;
  logic               w_rs_neg;
  logic               w_rt_neg;
  logic [WIDTH-1:0]   w_rs_mag;
  logic [WIDTH-1:0]   w_rt_mag;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_rem_sh;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rem_diff;
  logic [WIDTH-1:0]   w_rem_new;
  logic [2*WIDTH-1:0] w_div_next;
  logic [WIDTH-1:0]   w_fix_hi;
  logic [WIDTH-1:0]   w_fix_lo;

  assign w_accept = (r_state == S_IDLE) && bus.start && !bus.cancel;
  assign w_last   = (r_count == CW'(WIDTH - 1));

  // Signed ops work on magnitudes; the most negative value maps to itself as an unsigned number.
  assign w_signed = ~bus.op[0];
  assign w_rs_neg = w_signed & bus.rs_data[WIDTH-1];
  assign w_rt_neg = w_signed & bus.rt_data[WIDTH-1];
  assign w_rs_mag = w_rs_neg ? -bus.rs_data : bus.rs_data;
  assign w_rt_mag = w_rt_neg ? -bus.rt_data : bus.rt_data;

  // Multiply: {partial product, remaining multiplier bits} shifts right one bit per step.
  assign w_addend   = r_acc[0] ? r_b : '0;
  assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
  assign w_mul_next = {w_sum, r_acc[WIDTH-1:1]};

  // Divide: {remainder, dividend/quotient} shifts left; quotient bits enter at the bottom.
  assign w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_ge       = (w_rem_sh >= {1'b0, r_b});
  assign w_rem_diff = w_rem_sh[WIDTH-1:0] - r_b;
  assign w_rem_new  = w_ge ? w_rem_diff : w_rem_sh[WIDTH-1:0];
  assign w_div_next = {w_rem_new, r_acc[WIDTH-2:0], w_ge};

  // A zero divisor always "subtracts", giving an all-ones quotient and the dividend as remainder.
  always_comb begin
    w_fix_hi = r_acc[2*WIDTH-1:WIDTH];
    w_fix_lo = r_acc[WIDTH-1:0];
    if (r_is_div) begin
      if (r_neg_q) w_fix_lo = -r_acc[WIDTH-1:0];
      if (r_neg_r) w_fix_hi = -r_acc[2*WIDTH-1:WIDTH];
    end else if (r_neg_q) begin
      {w_fix_hi, w_fix_lo} = -r_acc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = S_CALC;
      S_CALC:  begin
        if (bus.cancel)  w_state_next = S_IDLE;
        else if (w_last) w_state_next = S_FIX;
      end
      S_FIX:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_is_div <= 1'b0;
      r_b      <= '0;
      r_acc    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_count  <= '0;
      r_out_hi <= '0;
      r_out_lo <= '0;
      r_write  <= 1'b0;
    end else begin
      r_write <= 1'b0;
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_is_div <= bus.op[1];
          r_b      <= w_rt_mag;
          r_acc    <= {{WIDTH{1'b0}}, w_rs_mag};
          r_neg_q  <= w_rs_neg ^ w_rt_neg;
          r_neg_r  <= w_rs_neg;
          r_count  <= '0;
        end
        S_CALC: begin
          r_acc   <= r_is_div ? w_div_next : w_mul_next;
          r_count <= r_count + CW'(1);
        end
        S_FIX: if (!bus.cancel) begin
          r_out_hi <= w_fix_hi;
          r_out_lo <= w_fix_lo;
          r_write  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (r_state != S_IDLE);
  assign bus.write_hi = r_write;
  assign bus.write_lo = r_write;
  assign bus.out_hi   = r_out_hi;
  assign bus.out_lo   = r_out_lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases, randomized ops against a
// 64-bit arithmetic model, back-to-back issue, cancel and mid-operation reset.
module tb_muldiv_unit;
  logic clk   = 1'b0;
  logic reset = 1'b1;

  muldiv_unit_if #(.WIDTH(32)) bus();
  muldiv_unit #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] last_hi  = '0;
  logic [31:0] last_lo  = '0;

  // Reference: plain 64-bit arithmetic; SV division truncates and % follows the dividend's sign.
  function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] rs,
                                            input logic [31:0] rt);
    longint      a;
    longint      b;
    logic [63:0] r;
    a = longint'($signed(rs));
    b = longint'($signed(rt));
    case (op)
      2'b00:   r = 64'(a * b);
      2'b01:   r = {32'b0, rs} * {32'b0, rt};
      2'b10: begin
        if (rt == 32'd0) r = {rs, (rs[31] ? 32'h0000_0001 : 32'hFFFF_FFFF)};
        else             r = {32'(a % b), 32'(a / b)};
      end
      default: begin
        if (rt == 32'd0) r = {rs, 32'hFFFF_FFFF};
        else             r = {rs % rt, rs / rt};
      end
    endcase
    return r;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.op      = op;
    bus.rs_data = rs;
    bus.rt_data = rt;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Counts edges from the issuing edge until write_hi is seen; bounded so it cannot hang.
  task automatic wait_pulse(output int n, output bit got, output int busy_bad);
    n = 0; got = 1'b0; busy_bad = 0;
    while (n < 60 && !got) begin
      @(negedge clk);
      if (bus.write_hi === 1'b1) got = 1'b1;
      else begin
        if (bus.busy !== 1'b1) busy_bad++;
        @(posedge clk);
        n++;
      end
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b1; bus.cancel = 1'b0; bus.op = 2'b01;
    bus.rs_data = 32'h1234_5678; bus.rt_data = 32'h9;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.write_hi !== 1'b0 || bus.write_lo !== 1'b0) begin n_fail++; $display("FAIL reset_write: got %b%b expected 00", bus.write_hi, bus.write_lo); end
    n_checks++; if (bus.out_hi !== 32'd0 || bus.out_lo !== 32'd0) begin n_fail++; $display("FAIL reset_out: got %h_%h expected 0", bus.out_hi, bus.out_lo); end
    reset = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy: got %b expected 0", bus.busy); end
    $display("reset: busy=%b out=%h_%h", bus.busy, bus.out_hi, bus.out_lo);
  endtask

  task automatic test_directed();
    logic [1:0]  d_op [6] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b10, 2'b10};
    logic [31:0] d_rs [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h5, 32'h8000_0000, 32'hFFFF_FFFB};
    logic [31:0] d_rt [6] = '{32'hFFFF_FFFF, 32'h2, 32'h2, 32'h0, 32'hFFFF_FFFF, 32'h0};
    logic [31:0] d_hi [6] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5, 32'h0, 32'hFFFF_FFFB};
    logic [31:0] d_lo [6] = '{32'h0000_0001, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001};
    int n; bit got; int bb;
    for (int i = 0; i < 6; i++) begin
      issue(d_op[i], d_rs[i], d_rt[i]);
      wait_pulse(n, got, bb);
      n_checks++; if (!got || n != 33) begin n_fail++; $display("FAIL dir%0d_latency: got %0d edges (seen=%b) expected 33", i, n, got); end
      n_checks++; if (bb != 0) begin n_fail++; $display("FAIL dir%0d_busy_during: got %0d low cycles expected 0", i, bb); end
      n_checks++; if (bus.out_hi !== d_hi[i] || bus.out_lo !== d_lo[i]) begin n_fail++; $display("FAIL dir%0d_result: got %h_%h expected %h_%h", i, bus.out_hi, bus.out_lo, d_hi[i], d_lo[i]); end
      n_checks++; if (bus.write_lo !== 1'b1 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL dir%0d_pulse: got write_lo=%b busy=%b expected 1 0", i, bus.write_lo, bus.busy); end
      $display("directed op=%0d rs=%h rt=%h -> hi=%h lo=%h", d_op[i], d_rs[i], d_rt[i], bus.out_hi, bus.out_lo);
      @(posedge clk); @(negedge clk);
      n_checks++; if (bus.write_hi !== 1'b0 || bus.out_hi !== d_hi[i] || bus.out_lo !== d_lo[i]) begin n_fail++; $display("FAIL dir%0d_hold: got write=%b out=%h_%h expected 0 %h_%h", i, bus.write_hi, bus.out_hi, bus.out_lo, d_hi[i], d_lo[i]); end
      last_hi = d_hi[i]; last_lo = d_lo[i];
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] rs, rt;
    logic [63:0] exp;
    int n; bit got; int bb;
    for (int i = 0; i < 30; i++) begin
      op  = 2'($urandom_range(0, 3));
      rs  = pick_operand();
      rt  = pick_operand();
      exp = ref_model(op, rs, rt);
      issue(op, rs, rt);
      wait_pulse(n, got, bb);
      n_checks++; if (!got || n != 33) begin n_fail++; $display("FAIL rnd%0d_latency: got %0d edges expected 33", i, n); end
      n_checks++; if ({bus.out_hi, bus.out_lo} !== exp) begin n_fail++; $display("FAIL rnd%0d_result op=%0d rs=%h rt=%h: got %h_%h expected %h_%h", i, op, rs, rt, bus.out_hi, bus.out_lo, exp[63:32], exp[31:0]); end
      $display("random op=%0d rs=%h rt=%h -> hi=%h lo=%h", op, rs, rt, bus.out_hi, bus.out_lo);
      last_hi = exp[63:32]; last_lo = exp[31:0];
    end
  endtask

  task automatic test_back_to_back();
    int n; bit got; int bb;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.rs_data = 32'd3; bus.rt_data = 32'd5;
    @(posedge clk);
    // Keep start high with different operands: ignored while busy, accepted in the pulse cycle.
    #1 bus.op = 2'b10; bus.rs_data = 32'hFFFF_FFF9; bus.rt_data = 32'd2;
    wait_pulse(n, got, bb);
    n_checks++; if (!got || n != 33) begin n_fail++; $display("FAIL b2b_first_latency: got %0d edges expected 33", n); end
    n_checks++; if (bus.out_hi !== 32'd0 || bus.out_lo !== 32'd15) begin n_fail++; $display("FAIL b2b_first_result: got %h_%h expected 00000000_0000000f", bus.out_hi, bus.out_lo); end
    $display("b2b first -> hi=%h lo=%h after %0d edges", bus.out_hi, bus.out_lo, n);
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_second_accept: got busy=%b expected 1", bus.busy); end
    wait_pulse(n, got, bb);
    n_checks++; if (!got || n != 32) begin n_fail++; $display("FAIL b2b_second_latency: got %0d edges expected 33", n + 1); end
    n_checks++; if (bus.out_hi !== 32'hFFFF_FFFF || bus.out_lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL b2b_second_result: got %h_%h expected ffffffff_fffffffd", bus.out_hi, bus.out_lo); end
    $display("b2b second -> hi=%h lo=%h", bus.out_hi, bus.out_lo);
    last_hi = 32'hFFFF_FFFF; last_lo = 32'hFFFF_FFFD;
    @(posedge clk);
  endtask

  task automatic test_cancel();
    int pulses;
    // start together with cancel in IDLE is ignored
    @(negedge clk);
    bus.start = 1'b1; bus.cancel = 1'b1; bus.op = 2'b01; bus.rs_data = 32'd7; bus.rt_data = 32'd9;
    @(posedge clk);
    #1 bus.start = 1'b0; bus.cancel = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL cancel_idle_start: got busy=%b expected 0", bus.busy); end
    // cancel in CALC iteration 10
    issue(2'b01, 32'd7, 32'd9);
    repeat (10) @(posedge clk);
    #1 bus.cancel = 1'b1;
    @(posedge clk);
    #1 bus.cancel = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL cancel_calc_busy: got %b expected 0", bus.busy); end
    pulses = 0;
    repeat (40) begin @(negedge clk); if (bus.write_hi !== 1'b0) pulses++; end
    n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL cancel_calc_pulse: got %0d pulse cycles expected 0", pulses); end
    n_checks++; if (bus.out_hi !== last_hi || bus.out_lo !== last_lo) begin n_fail++; $display("FAIL cancel_calc_hold: got %h_%h expected %h_%h", bus.out_hi, bus.out_lo, last_hi, last_lo); end
    $display("cancel in CALC: busy=%b out=%h_%h", bus.busy, bus.out_hi, bus.out_lo);
    // cancel in FIX
    issue(2'b00, 32'h0000_1234, 32'hFFFF_0001);
    repeat (32) @(posedge clk);
    #1 bus.cancel = 1'b1;
    @(posedge clk);
    #1 bus.cancel = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0 || bus.write_hi !== 1'b0) begin n_fail++; $display("FAIL cancel_fix: got busy=%b write=%b expected 0 0", bus.busy, bus.write_hi); end
    pulses = 0;
    repeat (10) begin @(negedge clk); if (bus.write_hi !== 1'b0) pulses++; end
    n_checks++; if (pulses != 0 || bus.out_hi !== last_hi || bus.out_lo !== last_lo) begin n_fail++; $display("FAIL cancel_fix_hold: got %0d pulses out=%h_%h expected 0 %h_%h", pulses, bus.out_hi, bus.out_lo, last_hi, last_lo); end
    $display("cancel in FIX: busy=%b out=%h_%h", bus.busy, bus.out_hi, bus.out_lo);
  endtask

  task automatic test_reset_mid();
    int pulses;
    issue(2'b00, 32'h0001_2345, 32'h0000_0777);
    repeat (20) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.out_hi !== 32'd0 || bus.out_lo !== 32'd0) begin n_fail++; $display("FAIL reset_mid_out: got %h_%h expected 0", bus.out_hi, bus.out_lo); end
    pulses = 0;
    repeat (40) begin @(negedge clk); if (bus.write_hi !== 1'b0) pulses++; end
    n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL reset_mid_pulse: got %0d pulse cycles expected 0", pulses); end
    $display("reset mid-op: busy=%b out=%h_%h", bus.busy, bus.out_hi, bus.out_lo);
  endtask

  initial begin
    bus.start = 1'b0; bus.cancel = 1'b0; bus.op = 2'b00;
    bus.rs_data = '0; bus.rt_data = '0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_cancel();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
